// File: rtl/frame_config_mem_shadowed.sv
// Shadowed frame configuration memory: frames are captured into a shadow
// array and copied to the active configuration in a single commit cycle.
// Also provides registered readback, dirty tracking, a saturating
// written-frame counter and sticky multi-hot strobe detection.
module frame_config_mem_shadowed #(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameBitsPerRow  = 32,
    parameter int unsigned NoConfigBits     = 640,
    parameter bit          EMULATION_ENABLE = 1'b0,
    parameter logic [NoConfigBits-1:0] EMULATION_CONFIG = '0,
    parameter int unsigned CountWidth       = 8,
    localparam int unsigned FrameIdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       ConfigCommit,
    input  logic                       ReadReq,
    input  logic                       ReadSrc,
    input  logic [FrameIdxW-1:0]       ReadFrame,
    output logic [FrameBitsPerRow-1:0] ReadData,
    output logic                       ReadValid,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       ShadowDirty,
    output logic [CountWidth-1:0]      FramesWritten,
    output logic                       StrobeError
);

    localparam int unsigned TotalBits = MaxFramesPerCol * FrameBitsPerRow;
    localparam logic [NoConfigBits-1:0] ActiveResetVal =
        EMULATION_ENABLE ? EMULATION_CONFIG : '0;

    logic [TotalBits-1:0]       shadow_q;
    logic [NoConfigBits-1:0]    active_q;
    logic [TotalBits-1:0]       active_ext;
    logic [FrameBitsPerRow-1:0] read_sel_c;
    logic                       any_strobe;
    logic                       multi_strobe;
    logic                       count_sat;

    assign any_strobe   = |FrameStrobe;
    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi_strobe = (FrameStrobe & (FrameStrobe - MaxFramesPerCol'(1))) != '0;
    assign count_sat    = &FramesWritten;

    assign ConfigBits   = active_q;
    assign ConfigBits_N = ~active_q;

    // Active bits laid out in frame space; positions past NoConfigBits read as zero.
    always_comb begin
        active_ext = '0;
        active_ext[NoConfigBits-1:0] = active_q;
    end

    // Readback source mux; an index with no matching frame yields zero.
    always_comb begin
        read_sel_c = '0;
        for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
            if (ReadFrame == FrameIdxW'(f)) begin
                read_sel_c = ReadSrc ? active_ext[f*FrameBitsPerRow +: FrameBitsPerRow]
                                     : shadow_q[f*FrameBitsPerRow +: FrameBitsPerRow];
            end
        end
    end

    // Shadow capture: every strobed frame loads the same payload.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            shadow_q <= '0;
        end else begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                if (FrameStrobe[f]) begin
                    shadow_q[f*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
                end
            end
        end
    end

    // Commit copies the pre-edge shadow, so a same-cycle write stays in shadow only.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            active_q <= ActiveResetVal;
        end else if (ConfigCommit) begin
            active_q <= shadow_q[NoConfigBits-1:0];
        end
    end

    // Dirty flag and saturating write counter; a write in the commit cycle counts as the first.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ShadowDirty   <= 1'b0;
            FramesWritten <= '0;
        end else if (ConfigCommit) begin
            ShadowDirty   <= any_strobe;
            FramesWritten <= any_strobe ? CountWidth'(1) : '0;
        end else if (any_strobe) begin
            ShadowDirty <= 1'b1;
            if (!count_sat) begin
                FramesWritten <= FramesWritten + CountWidth'(1);
            end
        end
    end

    // Sticky multi-hot strobe flag, cleared only by reset.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            StrobeError <= 1'b0;
        end else if (multi_strobe) begin
            StrobeError <= 1'b1;
        end
    end

    // Readback pipeline: one result per request, data holds when idle.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ReadValid <= 1'b0;
            ReadData  <= '0;
        end else begin
            ReadValid <= ReadReq;
            if (ReadReq) begin
                ReadData <= read_sel_c;
            end
        end
    end

endmodule
